// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the cache-to-memory path: bus widths, the request
// tag field layout and the state type used by the cache arbiter.
//
// Tag layout (TAGWIDTH bits):
//   [TAGWIDTH-1]  READ (0) / WRITE (1)
//   [TAGWIDTH-2]  MEMORY marker, set on every request bound for memory
//   [TAGWIDTH-3:0] requester-private sequence/id bits, passed through as-is
// ---------------------------------------------------------------------------
package cache_pkg;

    localparam int ADDRW    = 64;
    localparam int BLOCKW   = 512;
    localparam int TAGWIDTH = 13;

    localparam int TAG_RW_BIT  = TAGWIDTH - 1;
    localparam int TAG_MEM_BIT = TAGWIDTH - 2;

    localparam logic [TAGWIDTH-1:0] READ   = 13'h0000;
    localparam logic [TAGWIDTH-1:0] WRITE  = 13'h1000;
    localparam logic [TAGWIDTH-1:0] MEMORY = 13'h0800;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        RETURN    = 2'd3
    } arb_state_t;

    // Informational helper for stages that care about transaction direction.
    // The arbiter itself never decodes tags.
    function automatic logic tag_is_write(input logic [TAGWIDTH-1:0] tag);
        return tag[TAG_RW_BIT];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Purely combinational two-way round-robin pick.
//
// Ports:
//   reqs[1:0]    request lines, bit i = client i
//   last_grant   index of the client granted most recently
//   grant_valid  at least one request present
//   grant_idx    chosen client; on contention the one not granted last time
// ---------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic [1:0] reqs,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    // A lone requester always wins; only a tie consults the history bit.
    always_comb begin
        grant_valid = |reqs;
        grant_idx   = 1'b0;
        if (reqs == 2'b11) begin
            grant_idx = ~last_grant;
        end else begin
            grant_idx = reqs[1];
        end
    end

endmodule

// File: rtl/mod_cache_arbiter.sv
// ---------------------------------------------------------------------------
// mod_cache_arbiter
// Merges L1 icache (client 0) and dcache (client 1) block requests onto one
// memory bus. One transaction in flight at a time, round-robin between the
// clients, response routed back to the client that owns the transaction.
// Every output is a register; nothing combinational reaches an output.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   c_req/c_reqtag/c_reqdata    per-client request address/tag/write data
//   c_reqcyc / c_reqack         per-client request valid / accept pulse
//   c_resp/c_resptag            per-client response data/tag
//   c_respcyc / c_respack       per-client response valid / accept
//   m_req/m_reqtag/m_reqdata    memory request address/tag/write data
//   m_reqcyc / m_reqack         memory request valid / accept
//   m_resp/m_resptag            memory response data/tag
//   m_respcyc / m_respack       memory response valid / accept
// ---------------------------------------------------------------------------
module mod_cache_arbiter #(
    parameter int ADDRW    = cache_pkg::ADDRW,
    parameter int BLOCKW   = cache_pkg::BLOCKW,
    parameter int TAGWIDTH = cache_pkg::TAGWIDTH,
    parameter int NCLIENT  = 2
) (
    input  logic                               clk,
    input  logic                               reset,

    input  logic [NCLIENT-1:0][ADDRW-1:0]      c_req,
    input  logic [NCLIENT-1:0][TAGWIDTH-1:0]   c_reqtag,
    input  logic [NCLIENT-1:0][BLOCKW-1:0]     c_reqdata,
    input  logic [NCLIENT-1:0]                 c_reqcyc,
    output logic [NCLIENT-1:0]                 c_reqack,
    output logic [NCLIENT-1:0][BLOCKW-1:0]     c_resp,
    output logic [NCLIENT-1:0][TAGWIDTH-1:0]   c_resptag,
    output logic [NCLIENT-1:0]                 c_respcyc,
    input  logic [NCLIENT-1:0]                 c_respack,

    output logic [ADDRW-1:0]                   m_req,
    output logic [TAGWIDTH-1:0]                m_reqtag,
    output logic [BLOCKW-1:0]                  m_reqdata,
    output logic                               m_reqcyc,
    input  logic                               m_reqack,
    input  logic [BLOCKW-1:0]                  m_resp,
    input  logic [TAGWIDTH-1:0]                m_resptag,
    input  logic                               m_respcyc,
    output logic                               m_respack
);

    import cache_pkg::*;

    arb_state_t state;
    logic       owner;
    logic       last_grant;
    logic       grant_valid;
    logic       grant_idx;

    rr_arbiter2 u_rr (
        .reqs        (c_reqcyc),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Single transaction FSM plus all datapath registers. last_grant resets
    // to 1 so the first contested grant lands on the icache. Requests are
    // only sampled in IDLE, so a pending non-owner simply waits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            c_reqack   <= '0;
            c_resp     <= '0;
            c_resptag  <= '0;
            c_respcyc  <= '0;
            m_req      <= '0;
            m_reqtag   <= '0;
            m_reqdata  <= '0;
            m_reqcyc   <= 1'b0;
            m_respack  <= 1'b0;
        end else begin
            c_reqack <= '0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        m_req                <= c_req[grant_idx];
                        m_reqtag             <= c_reqtag[grant_idx];
                        m_reqdata            <= c_reqdata[grant_idx];
                        m_reqcyc             <= 1'b1;
                        c_reqack[grant_idx]  <= 1'b1;
                        owner                <= grant_idx;
                        last_grant           <= grant_idx;
                        state                <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_reqack) begin
                        m_reqcyc <= 1'b0;
                        // A response arriving together with the accept is
                        // taken immediately, skipping WAIT_RESP.
                        if (m_respcyc) begin
                            c_resp[owner]    <= m_resp;
                            c_resptag[owner] <= m_resptag;
                            c_respcyc[owner] <= 1'b1;
                            state            <= RETURN;
                        end else begin
                            m_respack <= 1'b1;
                            state     <= WAIT_RESP;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (m_respcyc) begin
                        c_resp[owner]    <= m_resp;
                        c_resptag[owner] <= m_resptag;
                        c_respcyc[owner] <= 1'b1;
                        m_respack        <= 1'b0;
                        state            <= RETURN;
                    end
                end
                RETURN: begin
                    if (c_respack[owner]) begin
                        c_respcyc <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory must only answer while a transaction is actually outstanding.
    a_resp_only_when_outstanding: assert property (
        @(posedge clk) disable iff (!reset)
        m_respcyc |-> (state == ISSUE || state == WAIT_RESP));

    // Responses are routed to exactly one owner.
    a_single_respcyc: assert property (
        @(posedge clk) disable iff (!reset)
        $onehot0(c_respcyc));

endmodule

// File: tb/tb_mod_cache_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mod_cache_arbiter
// Directed bench for mod_cache_arbiter. Inputs change 1 time unit after the
// rising edge and outputs are checked at that same point, i.e. away from the
// active edge. A small hand-driven memory/client sequence in serve() walks a
// transaction through grant, issue, memory response and return.
// ---------------------------------------------------------------------------
module tb_mod_cache_arbiter;

    logic                   clk = 1'b0;
    logic                   reset;

    logic [1:0][63:0]       c_req;
    logic [1:0][12:0]       c_reqtag;
    logic [1:0][511:0]      c_reqdata;
    logic [1:0]             c_reqcyc;
    logic [1:0]             c_reqack;
    logic [1:0][511:0]      c_resp;
    logic [1:0][12:0]       c_resptag;
    logic [1:0]             c_respcyc;
    logic [1:0]             c_respack;

    logic [63:0]            m_req;
    logic [12:0]            m_reqtag;
    logic [511:0]           m_reqdata;
    logic                   m_reqcyc;
    logic                   m_reqack;
    logic [511:0]           m_resp;
    logic [12:0]            m_resptag;
    logic                   m_respcyc;
    logic                   m_respack;

    int checks   = 0;
    int failures = 0;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    mod_cache_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .c_req     (c_req),
        .c_reqtag  (c_reqtag),
        .c_reqdata (c_reqdata),
        .c_reqcyc  (c_reqcyc),
        .c_reqack  (c_reqack),
        .c_resp    (c_resp),
        .c_resptag (c_resptag),
        .c_respcyc (c_respcyc),
        .c_respack (c_respack),
        .m_req     (m_req),
        .m_reqtag  (m_reqtag),
        .m_reqdata (m_reqdata),
        .m_reqcyc  (m_reqcyc),
        .m_reqack  (m_reqack),
        .m_resp    (m_resp),
        .m_resptag (m_resptag),
        .m_respcyc (m_respcyc),
        .m_respack (m_respack)
    );

    task automatic check_output(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check_output({name, ".c_reqack"},  512'(c_reqack),  512'd0);
        check_output({name, ".c_respcyc"}, 512'(c_respcyc), 512'd0);
        check_output({name, ".c_resp0"},   c_resp[0],       512'd0);
        check_output({name, ".c_resp1"},   c_resp[1],       512'd0);
        check_output({name, ".c_resptag"}, 512'(c_resptag), 512'd0);
        check_output({name, ".m_req"},     512'(m_req),     512'd0);
        check_output({name, ".m_reqtag"},  512'(m_reqtag),  512'd0);
        check_output({name, ".m_reqdata"}, m_reqdata,       512'd0);
        check_output({name, ".m_reqcyc"},  512'(m_reqcyc),  512'd0);
        check_output({name, ".m_respack"}, 512'(m_respack), 512'd0);
    endtask

    // Runs one transaction starting from IDLE with requests already driven.
    // g is the client expected to win; ack_dly = cycles memory withholds
    // m_reqack; resp_dly = memory latency after accept (0 = same cycle);
    // rack_dly = cycles the client withholds c_respack.
    task automatic serve(input string name, input int g,
                         input logic [63:0] addr, input logic [12:0] tag, input logic [511:0] wdata,
                         input logic [511:0] rdata, input logic [12:0] rtag,
                         input int ack_dly, input int resp_dly, input int rack_dly,
                         input bit drop_req);
        logic [1:0] onehot;
        onehot = (g == 0) ? 2'b01 : 2'b10;

        tick();
        check_output({name, ".grant"},     512'(c_reqack), 512'(onehot));
        check_output({name, ".m_reqcyc"},  512'(m_reqcyc), 512'd1);
        check_output({name, ".m_req"},     512'(m_req),    512'(addr));
        check_output({name, ".m_reqtag"},  512'(m_reqtag), 512'(tag));
        check_output({name, ".m_reqdata"}, m_reqdata,      wdata);
        if (drop_req) c_reqcyc[g] = 1'b0;

        for (int i = 0; i < ack_dly; i++) begin
            tick();
            check_output({name, ".hold_reqack"}, 512'(c_reqack), 512'd0);
            check_output({name, ".hold_reqcyc"}, 512'(m_reqcyc), 512'd1);
            check_output({name, ".hold_req"},    512'(m_req),    512'(addr));
            check_output({name, ".hold_data"},   m_reqdata,      wdata);
        end

        m_reqack = 1'b1;
        if (resp_dly == 0) begin
            m_respcyc = 1'b1;
            m_resp    = rdata;
            m_resptag = rtag;
        end
        tick();
        m_reqack  = 1'b0;
        m_respcyc = 1'b0;

        if (resp_dly != 0) begin
            check_output({name, ".issued"},    512'(m_reqcyc),  512'd0);
            check_output({name, ".respack"},   512'(m_respack), 512'd1);
            check_output({name, ".ack_pulse"}, 512'(c_reqack),  512'd0);
            for (int i = 1; i < resp_dly; i++) begin
                tick();
                check_output({name, ".wait_respcyc"}, 512'(c_respcyc), 512'd0);
                check_output({name, ".wait_respack"}, 512'(m_respack), 512'd1);
            end
            m_respcyc = 1'b1;
            m_resp    = rdata;
            m_resptag = rtag;
            tick();
            m_respcyc = 1'b0;
        end

        check_output({name, ".respcyc"},   512'(c_respcyc),    512'(onehot));
        check_output({name, ".resp"},      c_resp[g],          rdata);
        check_output({name, ".resptag"},   512'(c_resptag[g]), 512'(rtag));
        check_output({name, ".m_respack"}, 512'(m_respack),    512'd0);
        check_output({name, ".m_reqcyc"},  512'(m_reqcyc),     512'd0);

        for (int i = 0; i < rack_dly; i++) begin
            tick();
            check_output({name, ".ret_respcyc"}, 512'(c_respcyc), 512'(onehot));
            check_output({name, ".ret_resp"},    c_resp[g],       rdata);
            check_output({name, ".ret_reqack"},  512'(c_reqack),  512'd0);
        end

        c_respack[g] = 1'b1;
        tick();
        c_respack[g] = 1'b0;
        check_output({name, ".done"}, 512'(c_respcyc), 512'd0);
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence.
    initial begin
        logic [511:0] wb_data;
        logic [511:0] i_data;
        logic [511:0] d_data;
        wb_data = {8{64'h1234_5678_9ABC_DEF0}};
        i_data  = {16{32'h0101_0101}};
        d_data  = {16{32'hD0D0_D0D0}};

        reset     = 1'b0;
        c_req     = '0;
        c_reqtag  = '0;
        c_reqdata = '0;
        c_reqcyc  = '0;
        c_respack = '0;
        m_reqack  = 1'b0;
        m_resp    = '0;
        m_resptag = '0;
        m_respcyc = 1'b0;

        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check_all_zero("post_reset");

        // Both clients request from reset and hold: icache, dcache, icache.
        $display("[TB] simultaneous requests");
        c_req[0]     = 64'h0000_0000_0000_2000;
        c_reqtag[0]  = 13'h0802;
        c_reqdata[0] = i_data;
        c_req[1]     = 64'h0000_0000_0000_3000;
        c_reqtag[1]  = 13'h0805;
        c_reqdata[1] = d_data;
        c_reqcyc     = 2'b11;
        serve("rr1", 0, 64'h2000, 13'h0802, i_data, {64{8'h11}}, 13'h0802, 0, 2, 0, 1'b0);
        serve("rr2", 1, 64'h3000, 13'h0805, d_data, {64{8'h22}}, 13'h0805, 0, 2, 0, 1'b0);
        serve("rr3", 0, 64'h2000, 13'h0802, i_data, {64{8'h33}}, 13'h0802, 0, 2, 0, 1'b0);
        c_reqcyc = 2'b00;

        // Single dcache read, memory latency 5.
        $display("[TB] single dcache read");
        c_req[1]    = 64'h0000_0000_0040_1000;
        c_reqtag[1] = 13'h0801;
        c_reqcyc    = 2'b10;
        serve("dread", 1, 64'h0040_1000, 13'h0801, d_data, {64{8'hAA}}, 13'h0801, 1, 5, 0, 1'b1);

        // Dirty writeback then a read of the same block.
        $display("[TB] dirty writeback");
        c_req[1]     = 64'h0000_0000_0000_8000;
        c_reqtag[1]  = 13'h1800;
        c_reqdata[1] = wb_data;
        c_reqcyc     = 2'b10;
        serve("wb", 1, 64'h8000, 13'h1800, wb_data, {64{8'h00}}, 13'h1800, 0, 3, 0, 1'b1);
        c_reqtag[1]  = 13'h0800;
        c_reqdata[1] = d_data;
        c_reqcyc     = 2'b10;
        serve("wb_rd", 1, 64'h8000, 13'h0800, d_data, {64{8'h5C}}, 13'h0800, 0, 2, 0, 1'b1);

        // Backpressure on icache with dcache waiting; dcache served after.
        $display("[TB] backpressure");
        c_req[0]    = 64'h0000_0000_0000_4040;
        c_reqtag[0] = 13'h0807;
        c_req[1]    = 64'h0000_0000_0000_5080;
        c_reqtag[1] = 13'h0809;
        c_reqcyc    = 2'b11;
        serve("bp_i", 0, 64'h4040, 13'h0807, i_data, {64{8'h77}}, 13'h0807, 7, 3, 4, 1'b1);
        serve("bp_d", 1, 64'h5080, 13'h0809, d_data, {64{8'h88}}, 13'h0809, 0, 1, 0, 1'b1);

        // Accept and response in the same ISSUE cycle.
        $display("[TB] same-cycle ack and response");
        c_req[0]    = 64'h0000_0000_0000_6000;
        c_reqtag[0] = 13'h080A;
        c_reqcyc    = 2'b01;
        serve("same", 0, 64'h6000, 13'h080A, i_data, {64{8'h99}}, 13'h080A, 0, 0, 1, 1'b1);

        // Reset while waiting for memory.
        $display("[TB] reset mid-transaction");
        c_req[1]    = 64'h0000_0000_0000_C000;
        c_reqtag[1] = 13'h0803;
        c_reqcyc    = 2'b10;
        tick();
        check_output("mid.grant", 512'(c_reqack), 512'd2);
        c_reqcyc = 2'b00;
        m_reqack = 1'b1;
        tick();
        m_reqack = 1'b0;
        check_output("mid.wait_respack", 512'(m_respack), 512'd1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("mid_async");
        tick();
        reset = 1'b1;
        tick();
        check_all_zero("mid_release");

        c_req[0]    = 64'h0000_0000_0000_7000;
        c_reqtag[0] = 13'h080B;
        c_reqcyc    = 2'b01;
        serve("after_rst", 0, 64'h7000, 13'h080B, i_data, {64{8'hBE}}, 13'h080B, 0, 2, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod_cache_arbiter.md
Name: mod_cache_arbiter

Overview:
- Sits directly downstream of the L1 instruction and data caches. Merges their block-level memory requests onto the single memory-side bus.
- Round-robin arbitration between the two caches; exactly one transaction outstanding at a time.
- Request address, tag and data are forwarded unchanged. The response is routed back to the cache that owns the transaction.
- Each cache sees the same request/response handshake it would see from memory directly.

Parameters:
- ADDRW, 64, request address width.
- BLOCKW, 512, cache block width (64 B) for reqdata/resp.
- TAGWIDTH, 13, request/response tag width; MSB = READ/WRITE.
- NCLIENT, 2, requester count (0 = icache, 1 = dcache); fixed at 2 in this revision.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- c_req[i]  in  ADDRW  client i block address (i = 0 icache, 1 dcache)
- c_reqtag[i]  in  TAGWIDTH  client i tag
- c_reqdata[i]  in  BLOCKW  client i write data
- c_reqcyc[i]  in  1  client i request valid
- c_reqack[i]  out  1  client i request accepted (1-cycle pulse)
- c_resp[i]  out  BLOCKW  response data to client i
- c_resptag[i]  out  TAGWIDTH  response tag to client i
- c_respcyc[i]  out  1  response valid to client i
- c_respack[i]  in  1  client i accepts response
- m_req  out  ADDRW  memory request address
- m_reqtag  out  TAGWIDTH  memory request tag
- m_reqdata  out  BLOCKW  memory write data
- m_reqcyc  out  1  memory request valid
- m_reqack  in  1  memory accepted request
- m_resp  in  BLOCKW  memory response data
- m_resptag  in  TAGWIDTH  memory response tag
- m_respcyc  in  1  memory response valid
- m_respack  out  1  arbiter accepts memory response

Behaviour:
- Reset (reset == 0, asynchronous):
  - All outputs 0.
  - state = IDLE, owner = 0, last_grant = 1, so the first contested grant goes to icache.
  - Reset mid-transaction abandons the transaction. No response is delivered after reset deasserts.
- All registered outputs; no combinational path from any input to any output.
- States:
  - IDLE:
    - If exactly one c_reqcyc is high, grant that client.
    - If both are high, grant ~last_grant.
    - On grant: latch req/reqtag/reqdata into the m_* registers; set m_reqcyc = 1; pulse c_reqack[g] = 1 for one cycle; owner = g; last_grant = g; go to ISSUE.
    - If neither is high, stay.
  - ISSUE:
    - Hold m_* stable with m_reqcyc = 1 until m_reqack == 1 is sampled.
    - That cycle: m_reqcyc <= 0 and go to WAIT_RESP.
    - If m_respcyc arrives in the same cycle as m_reqack, handle it as in WAIT_RESP in that same cycle.
  - WAIT_RESP:
    - m_respack = 1 while in this state.
    - When m_respcyc == 1: latch m_resp into c_resp[owner] and m_resptag into c_resptag[owner]; c_respcyc[owner] <= 1; m_respack <= 0; go to RETURN.
  - RETURN:
    - Hold c_respcyc[owner] = 1 and its data stable until c_respack[owner] == 1.
    - Then c_respcyc <= 0 and go to IDLE.
    - Earliest next grant is the cycle after leaving RETURN.
- Write requests (tag MSB = WRITE) still wait for a memory response, which the dcache uses as write completion.
- Tags are never altered or decoded for routing; owner is the sole routing key.
- A client dropping c_reqcyc before c_reqack has no effect, because a grant occurs only in IDLE.
- The non-owner's c_reqcyc stays pending. Its c_reqack and c_respcyc stay 0.
- Fairness: with both clients requesting continuously, grants strictly alternate.
- Minimum latency, request to response: grant cycle + 1 (ISSUE) + memory latency + 1 (RETURN).
- Assertions (simulation only):
  - m_respcyc is never sampled in IDLE or RETURN.
  - At most one c_respcyc is high at a time.

Decomposition:
- Shared package cache_pkg holds:
  - READ/WRITE and MEMORY tag field constants.
  - Width constants ADDRW/BLOCKW/TAGWIDTH.
  - The arb_state_t enum {IDLE, ISSUE, WAIT_RESP, RETURN}.
- One natural sub-module: rr_arbiter2. It is combinational, taking reqs[1:0] and last_grant and producing grant_valid and grant_idx; it is reused by later multi-port stages.
- The state machine and datapath registers stay in mod_cache_arbiter.

Test Plan:
- Single dcache read:
  - Stimulus: c_reqcyc[1] = 1, req = 0x0000_0000_0040_1000, tag = READ|MEMORY|0x01.
  - Required: c_reqack[1] pulses 1 cycle; m_req = 0x401000 with same tag. Memory returns 0xAA..AA after 5 cycles. c_resp[1] = 0xAA..AA with matching tag; c_respcyc[0] stays 0.
- Simultaneous requests from reset:
  - Stimulus: both c_reqcyc high, both held.
  - Required: icache is granted first, then dcache, then icache (strict alternation across 3 transactions).
- Dirty writeback:
  - Stimulus: dcache tag = WRITE|MEMORY|0x00, reqdata = 512'h1234…, addr 0x8000.
  - Required: m_reqdata is bit-exact to reqdata; the write response is returned to client 1; a subsequent READ of 0x8000 is forwarded normally.
- Backpressure:
  - Stimulus: m_reqack delayed 7 cycles; c_respack[0] delayed 4 cycles.
  - Required: m_* and c_resp[0] stay stable throughout; no second grant occurs.
- Reset mid-transaction:
  - Stimulus: assert reset in WAIT_RESP.
  - Required: all outputs 0 asynchronously, without waiting for a clock edge. After release, a stale m_respcyc triggers the assertion. A new icache request is serviced normally.
- Same-cycle ack and response:
  - Stimulus: m_reqack and m_respcyc high together in ISSUE.
  - Required: RETURN is entered next cycle and the response is delivered correctly.
